gaussian_window_feeder: RTL and testbench

- Producer side of the Gaussian filter's 3x3 tap interface (Ix0..Ix8 plus start).
- Accepts a raster-order pixel stream, one pixel per accepted beat, and buffers two image lines.
- Emits every fully-populated 3x3 neighbourhood as nine signed taps with a start qualifier.
- Holds each window stable long enough for the every-other-cycle sampling filter to capture it.

---
 rtl/gaussian_window_feeder.sv | 126 ++++++++++++
 tb/tb_gaussian_window_feeder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gaussian_window_feeder.sv
// Raster-stream to 3x3 window feeder for the Gaussian filter tap interface.
// Buffers two lines and presents each full neighbourhood on Ix0..Ix8, held with start for HOLD_CYCLES.
//
// state  | meaning
// STREAM | accepting pixels, in_ready high
// HOLD   | window on Ix0..Ix8 valid, start high, input stalled
module gaussian_window_feeder #(
   parameter int DATA_W      = 27,
   parameter int IMG_W       = 64,
   parameter int IMG_H       = 64,
   parameter int HOLD_CYCLES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     in_ready,
   output logic signed [DATA_W-1:0] Ix0,
   output logic signed [DATA_W-1:0] Ix1,
   output logic signed [DATA_W-1:0] Ix2,
   output logic signed [DATA_W-1:0] Ix3,
   output logic signed [DATA_W-1:0] Ix4,
   output logic signed [DATA_W-1:0] Ix5,
   output logic signed [DATA_W-1:0] Ix6,
   output logic signed [DATA_W-1:0] Ix7,
   output logic signed [DATA_W-1:0] Ix8,
   output logic                     start,
   output logic                     frame_done
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   typedef enum logic {STREAM, HOLD} state_t;

   state_t                     state, state_nxt;
   logic [HW-1:0]              hold_cnt, hold_nxt;
   logic                       start_nxt;
   logic [CW-1:0]              col;
   logic [RW-1:0]              row;
   logic signed [DATA_W-1:0]   line_a [IMG_W];
   logic signed [DATA_W-1:0]   line_b [IMG_W];
   logic signed [DATA_W-1:0]   tap [9];
   logic                       accept, emit, last_col, last_row;

   assign in_ready = (state == STREAM) && !rst;
   assign accept   = in_valid && in_ready;
   assign last_col = (col == CW'(IMG_W - 1));
   assign last_row = (row == RW'(IMG_H - 1));
   assign emit     = accept && (row >= RW'(2)) && (col >= CW'(2));

   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      start_nxt = 1'b0;
      case (state)
         STREAM: begin
            if (emit) begin
               state_nxt = HOLD;
               hold_nxt  = HW'(HOLD_CYCLES - 1);
               start_nxt = 1'b1;
            end
         end
         HOLD: begin
            if (hold_cnt == '0) begin
               state_nxt = STREAM;
            end else begin
               hold_nxt  = hold_cnt - 1'b1;
               start_nxt = 1'b1;
            end
         end
         default: state_nxt = STREAM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= STREAM;
         hold_cnt   <= '0;
         start      <= 1'b0;
         frame_done <= 1'b0;
         col        <= '0;
         row        <= '0;
         for (int i = 0; i < 9; i++) tap[i] <= '0;
      end else begin
         state      <= state_nxt;
         hold_cnt   <= hold_nxt;
         start      <= start_nxt;
         frame_done <= accept && last_col && last_row;
         if (accept) begin
            col <= last_col ? '0 : col + 1'b1;
            if (last_col) row <= last_row ? '0 : row + 1'b1;
            // new right column, top to bottom: row r-2, row r-1, row r
            tap[0] <= tap[1];
            tap[1] <= tap[2];
            tap[2] <= line_b[col];
            tap[3] <= tap[4];
            tap[4] <= tap[5];
            tap[5] <= line_a[col];
            tap[6] <= tap[7];
            tap[7] <= tap[8];
            tap[8] <= in_data;
         end
      end
   end

   // Line storage is never cleared; rows 0 and 1 of each frame overwrite it before use.
   always_ff @(posedge clk) begin
      if (accept) begin
         line_b[col] <= line_a[col];
         line_a[col] <= in_data;
      end
   end

   assign Ix0 = tap[0];
   assign Ix1 = tap[1];
   assign Ix2 = tap[2];
   assign Ix3 = tap[3];
   assign Ix4 = tap[4];
   assign Ix5 = tap[5];
   assign Ix6 = tap[6];
   assign Ix7 = tap[7];
   assign Ix8 = tap[8];

endmodule

// File: tb/tb_gaussian_window_feeder.sv
// Bench for gaussian_window_feeder on a 4x4 frame: expected windows are queued as pixels are driven
// and matched against windows captured from the tap outputs.
module tb_gaussian_window_feeder;

   localparam int DW   = 27;
   localparam int W    = 4;
   localparam int H    = 4;
   localparam int HOLD = 2;
   localparam int PW   = 9*DW + 7;

   typedef struct {
      logic [9*DW-1:0] taps;
      bit              fd;
      int              hold;
      bit              stable;
      bit              rlow;
   } win_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 in_valid = 1'b0;
   logic signed [DW-1:0] in_data = '0;
   logic                 in_ready, start, frame_done;
   logic signed [DW-1:0] Ix0, Ix1, Ix2, Ix3, Ix4, Ix5, Ix6, Ix7, Ix8;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int acc_cnt  = 0;
   int fd_cnt   = 0;

   win_t            obs_q[$];
   win_t            exp_q[$];
   win_t            cur;
   bit              prev_start = 1'b0;
   logic [DW-1:0]   pix [H][W];
   logic [9*DW-1:0] obs_taps;

   gaussian_window_feeder #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .HOLD_CYCLES(HOLD)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .Ix0(Ix0), .Ix1(Ix1), .Ix2(Ix2), .Ix3(Ix3), .Ix4(Ix4), .Ix5(Ix5), .Ix6(Ix6), .Ix7(Ix7), .Ix8(Ix8),
      .start(start), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   assign obs_taps = {Ix0, Ix1, Ix2, Ix3, Ix4, Ix5, Ix6, Ix7, Ix8};

   // Capture each window: taps at start rise, hold length, tap stability and in_ready during hold.
   always @(negedge clk) begin
      if (in_valid && in_ready) acc_cnt++;
      if (frame_done) fd_cnt++;
      if (start && !prev_start) begin
         cur.taps = obs_taps; cur.fd = frame_done; cur.hold = 1;
         cur.stable = 1'b1; cur.rlow = !in_ready;
      end else if (start) begin
         cur.hold++;
         if (obs_taps !== cur.taps) cur.stable = 1'b0;
         if (in_ready) cur.rlow = 1'b0;
      end else if (prev_start) begin
         obs_q.push_back(cur);
      end
      prev_start = start;
   end

   function automatic logic [PW-1:0] pack_win(input win_t w);
      return {w.taps, w.fd, 4'(w.hold), w.stable, w.rlow};
   endfunction

   task automatic stream_frame(input int base, input int sgn, input bit gaps, input int npix);
      int r, c, n;
      win_t e;
      for (int k = 0; k < npix; k++) begin
         r = k / W;
         c = k % W;
         pix[r][c] = DW'(sgn * (base + 10*r + c));
         if (r >= 2 && c >= 2) begin
            e.taps = {pix[r-2][c-2], pix[r-2][c-1], pix[r-2][c],
                      pix[r-1][c-2], pix[r-1][c-1], pix[r-1][c],
                      pix[r][c-2],   pix[r][c-1],   pix[r][c]};
            e.fd = (k == W*H - 1);
            e.hold = HOLD; e.stable = 1'b1; e.rlow = 1'b1;
            exp_q.push_back(e);
         end
         if (gaps) begin
            while ($urandom_range(1, 0) == 1) begin
               in_valid = 1'b0;
               @(posedge clk); #1;
            end
         end
         in_valid = 1'b1;
         in_data  = pix[r][c];
         n = 0;
         @(negedge clk);
         while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
         end
         if (n >= 20) begin
            chk_cnt++;
            $display("FAIL accept_timeout: pixel %0d never accepted, in_ready=%b required 1", k, in_ready);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_cnt++; if (start !== 1'b0) $display("FAIL rst_start: got %b required 0", start); else pass_cnt++;
      chk_cnt++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done: got %b required 0", frame_done); else pass_cnt++;
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b required 0", in_ready); else pass_cnt++;
      chk_cnt++; if (obs_taps !== '0) $display("FAIL rst_taps: got %h required 0", obs_taps); else pass_cnt++;
      rst = 1'b0;
      #1;
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b required 1", in_ready); else pass_cnt++;
   endtask

   task automatic test_basic();
      int ob, ab, fb, i;
      win_t e;
      ob = obs_q.size(); ab = acc_cnt; fb = fd_cnt;
      stream_frame(0, 1, 1'b0, W*H);
      drain();
      chk_cnt++; if (obs_q.size() - ob != 4) $display("FAIL basic_count: got %0d windows required 4", obs_q.size() - ob); else pass_cnt++;
      chk_cnt++; if (acc_cnt - ab != 16) $display("FAIL basic_accepted: got %0d required 16", acc_cnt - ab); else pass_cnt++;
      chk_cnt++; if (fd_cnt - fb != 1) $display("FAIL basic_frame_done: got %0d pulses required 1", fd_cnt - fb); else pass_cnt++;
      if (obs_q.size() > ob) begin
         chk_cnt++;
         if (obs_q[ob].taps[4*DW +: DW] !== DW'(11)) $display("FAIL basic_first_centre: got %0d required 11", $signed(obs_q[ob].taps[4*DW +: DW]));
         else pass_cnt++;
      end
      i = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk_cnt++;
         if (ob + i >= obs_q.size()) $display("FAIL basic_win%0d: got none required %h", i, pack_win(e));
         else if (pack_win(obs_q[ob+i]) !== pack_win(e)) $display("FAIL basic_win%0d: got %h required %h", i, pack_win(obs_q[ob+i]), pack_win(e));
         else pass_cnt++;
         i++;
      end
   endtask

   task automatic test_gaps();
      int ob, ab, fb, i;
      win_t e;
      ob = obs_q.size(); ab = acc_cnt; fb = fd_cnt;
      stream_frame(0, 1, 1'b1, W*H);
      drain();
      chk_cnt++; if (obs_q.size() - ob != 4) $display("FAIL gaps_count: got %0d windows required 4", obs_q.size() - ob); else pass_cnt++;
      chk_cnt++; if (acc_cnt - ab != 16) $display("FAIL gaps_accepted: got %0d required 16", acc_cnt - ab); else pass_cnt++;
      chk_cnt++; if (fd_cnt - fb != 1) $display("FAIL gaps_frame_done: got %0d pulses required 1", fd_cnt - fb); else pass_cnt++;
      i = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk_cnt++;
         if (ob + i >= obs_q.size()) $display("FAIL gaps_win%0d: got none required %h", i, pack_win(e));
         else if (pack_win(obs_q[ob+i]) !== pack_win(e)) $display("FAIL gaps_win%0d: got %h required %h", i, pack_win(obs_q[ob+i]), pack_win(e));
         else pass_cnt++;
         i++;
      end
   endtask

   task automatic test_signed();
      int ob, i;
      win_t e;
      ob = obs_q.size();
      stream_frame(0, -1, 1'b0, W*H);
      drain();
      chk_cnt++; if (obs_q.size() - ob != 4) $display("FAIL signed_count: got %0d windows required 4", obs_q.size() - ob); else pass_cnt++;
      if (obs_q.size() > ob) begin
         chk_cnt++;
         if (obs_q[ob].taps[7*DW +: DW] !== 27'h7FF_FFFF) $display("FAIL signed_ix1: got %h required 7ffffff", obs_q[ob].taps[7*DW +: DW]);
         else pass_cnt++;
         chk_cnt++;
         if (obs_q[ob].taps[0 +: DW] !== 27'h7FF_FFEA) $display("FAIL signed_ix8: got %h required 7ffffea", obs_q[ob].taps[0 +: DW]);
         else pass_cnt++;
      end
      i = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk_cnt++;
         if (ob + i >= obs_q.size()) $display("FAIL signed_win%0d: got none required %h", i, pack_win(e));
         else if (pack_win(obs_q[ob+i]) !== pack_win(e)) $display("FAIL signed_win%0d: got %h required %h", i, pack_win(obs_q[ob+i]), pack_win(e));
         else pass_cnt++;
         i++;
      end
   endtask

   task automatic test_reset_mid_hold();
      int ob, ab, fb, i;
      win_t e;
      stream_frame(0, 1, 1'b0, 12);
      chk_cnt++; if (start !== 1'b1) $display("FAIL midhold_in_hold: start got %b required 1", start); else pass_cnt++;
      rst = 1'b1;
      @(posedge clk); #1;
      chk_cnt++; if (start !== 1'b0) $display("FAIL midhold_start: got %b required 0", start); else pass_cnt++;
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL midhold_in_ready: got %b required 0", in_ready); else pass_cnt++;
      chk_cnt++; if (frame_done !== 1'b0) $display("FAIL midhold_frame_done: got %b required 0", frame_done); else pass_cnt++;
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      @(posedge clk); #1;
      ob = obs_q.size(); ab = acc_cnt; fb = fd_cnt;
      stream_frame(0, 1, 1'b0, W*H);
      drain();
      chk_cnt++; if (obs_q.size() - ob != 4) $display("FAIL midhold_count: got %0d windows required 4", obs_q.size() - ob); else pass_cnt++;
      chk_cnt++; if (acc_cnt - ab != 16) $display("FAIL midhold_accepted: got %0d required 16", acc_cnt - ab); else pass_cnt++;
      chk_cnt++; if (fd_cnt - fb != 1) $display("FAIL midhold_frame_done_cnt: got %0d pulses required 1", fd_cnt - fb); else pass_cnt++;
      i = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk_cnt++;
         if (ob + i >= obs_q.size()) $display("FAIL midhold_win%0d: got none required %h", i, pack_win(e));
         else if (pack_win(obs_q[ob+i]) !== pack_win(e)) $display("FAIL midhold_win%0d: got %h required %h", i, pack_win(obs_q[ob+i]), pack_win(e));
         else pass_cnt++;
         i++;
      end
   endtask

   task automatic test_back_to_back();
      int ob, fb, i;
      win_t e;
      ob = obs_q.size(); fb = fd_cnt;
      stream_frame(0, 1, 1'b0, W*H);
      stream_frame(100, 1, 1'b0, W*H);
      drain();
      chk_cnt++; if (obs_q.size() - ob != 8) $display("FAIL b2b_count: got %0d windows required 8", obs_q.size() - ob); else pass_cnt++;
      chk_cnt++; if (fd_cnt - fb != 2) $display("FAIL b2b_frame_done: got %0d pulses required 2", fd_cnt - fb); else pass_cnt++;
      if (obs_q.size() > ob + 4) begin
         chk_cnt++;
         if (obs_q[ob+4].taps[4*DW +: DW] !== DW'(111)) $display("FAIL b2b_f2_centre: got %0d required 111", $signed(obs_q[ob+4].taps[4*DW +: DW]));
         else pass_cnt++;
      end
      i = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk_cnt++;
         if (ob + i >= obs_q.size()) $display("FAIL b2b_win%0d: got none required %h", i, pack_win(e));
         else if (pack_win(obs_q[ob+i]) !== pack_win(e)) $display("FAIL b2b_win%0d: got %h required %h", i, pack_win(obs_q[ob+i]), pack_win(e));
         else pass_cnt++;
         i++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, run did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      @(posedge clk); #1;
      test_basic();
      test_gaps();
      test_signed();
      test_reset_mid_hold();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
